trap_ctrl: RTL and testbench

TRAP_CTRL -- requirements
Module: trap_ctrl

---
 rtl/trap_ctrl_pkg.sv | 30 +++
 rtl/trap_arb.sv | 42 ++++
 rtl/trap_ctrl.sv | 135 +++++++++++++
 tb/tb_trap_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trap_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// trap_ctrl_pkg
// Shared definitions for the trap controller: event codes, CSR bit indices
// and the sequencing FSM state encoding.
// ---------------------------------------------------------------------------
package trap_ctrl_pkg;

    localparam logic [31:0] CODE_ILLEGAL   = 32'h0000_0002;
    localparam logic [31:0] CODE_MRET      = 32'h0000_000A;
    localparam logic [31:0] CODE_ECALL     = 32'h0000_000B;
    localparam logic [31:0] CODE_TIMER_INT = 32'h8000_0007;
    localparam logic [31:0] CODE_EXT_INT   = 32'h8000_000B;

    localparam int MSTATUS_MIE_BIT = 3;
    localparam int MIE_MTIE_BIT    = 7;
    localparam int MIE_MEIE_BIT    = 11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_COMMIT = 2'd2,
        ST_JUMP   = 2'd3
    } trap_state_e;

    // Only these synchronous event codes start a trap; anything else is dropped.
    function automatic logic is_known_exc(input logic [31:0] code);
        return (code == CODE_ECALL) || (code == CODE_ILLEGAL) || (code == CODE_MRET);
    endfunction

endpackage

// File: rtl/trap_arb.sv
// ---------------------------------------------------------------------------
// trap_arb
// Combinational priority selection of the pending trap event.
//   exc_valid_i / exc_code_i : synchronous pipeline event and its code
//   ext_int_i / timer_int_i  : level interrupt requests
//   glb_ie_i                 : global interrupt enable (mstatus.MIE)
//   meie_i / mtie_i          : per-source enables from mie
//   take_o                   : an event is pending and should be accepted
//   code_o                   : trap code of the winning event
// ---------------------------------------------------------------------------
module trap_arb
    import trap_ctrl_pkg::*;
(
    input  logic        exc_valid_i,
    input  logic [31:0] exc_code_i,
    input  logic        ext_int_i,
    input  logic        timer_int_i,
    input  logic        glb_ie_i,
    input  logic        meie_i,
    input  logic        mtie_i,
    output logic        take_o,
    output logic [31:0] code_o
);

    always_comb begin
        take_o = 1'b0;
        code_o = '0;
        // An unlisted exception code counts as no exception, so an enabled
        // interrupt may still win in the same cycle.
        if (exc_valid_i && is_known_exc(exc_code_i)) begin
            take_o = 1'b1;
            code_o = exc_code_i;
        end else if (ext_int_i && glb_ie_i && meie_i) begin
            take_o = 1'b1;
            code_o = CODE_EXT_INT;
        end else if (timer_int_i && glb_ie_i && mtie_i) begin
            take_o = 1'b1;
            code_o = CODE_TIMER_INT;
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// ---------------------------------------------------------------------------
// trap_ctrl
// Sequences a trap from acceptance through CSR update and PC redirect.
//   clk, rst             : clock, synchronous active-high reset
//   exc_valid_i/code_i   : synchronous pipeline event
//   inst_addr_i          : address of the trapping instruction
//   ext_int_i/timer_int_i: level interrupt requests
//   mstatus/mie/mtvec/mepc_i : current CSR values
//   stall_i              : pipeline busy, delays commit
//   excepttype_o/inst_addr_o : one-cycle CSR update (COMMIT)
//   hold_o               : front-end stall while sequencing
//   flush_o/new_pc_o     : one-cycle redirect (JUMP)
//
// state  | meaning
// IDLE   | no trap in flight, arbitrate pending events
// WAIT   | event latched, waiting for stall_i to drop
// COMMIT | present latched code/address to the CSR file
// JUMP   | flush the pipeline and redirect to handler / mepc
// ---------------------------------------------------------------------------
module trap_ctrl
    import trap_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        exc_valid_i,
    input  logic [31:0] exc_code_i,
    input  logic [31:0] inst_addr_i,
    input  logic        ext_int_i,
    input  logic        timer_int_i,
    input  logic [31:0] mstatus_i,
    input  logic [31:0] mie_i,
    input  logic [31:0] mtvec_i,
    input  logic [31:0] mepc_i,
    input  logic        stall_i,
    output logic [31:0] excepttype_o,
    output logic [31:0] inst_addr_o,
    output logic        hold_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o
);

    trap_state_e state_q;
    logic [31:0] code_q;
    logic [31:0] addr_q;
    logic [31:0] excepttype_q;
    logic [31:0] inst_addr_q;
    logic        hold_q;
    logic        flush_q;
    logic [31:0] new_pc_q;

    logic        arb_take;
    logic [31:0] arb_code;
    logic [31:0] jump_target_d;
    logic        unused_csr;

    // Only a handful of CSR bits matter here.
    assign unused_csr = ^{mstatus_i, mie_i, mtvec_i[1:0]};

    trap_arb u_arb (
        .exc_valid_i (exc_valid_i),
        .exc_code_i  (exc_code_i),
        .ext_int_i   (ext_int_i),
        .timer_int_i (timer_int_i),
        .glb_ie_i    (mstatus_i[MSTATUS_MIE_BIT]),
        .meie_i      (mie_i[MIE_MEIE_BIT]),
        .mtie_i      (mie_i[MIE_MTIE_BIT]),
        .take_o      (arb_take),
        .code_o      (arb_code)
    );

    assign jump_target_d = (code_q == CODE_MRET) ? mepc_i : {mtvec_i[31:2], 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            code_q       <= '0;
            addr_q       <= '0;
            excepttype_q <= '0;
            inst_addr_q  <= '0;
            hold_q       <= 1'b0;
            flush_q      <= 1'b0;
            new_pc_q     <= '0;
        end else begin
            // One-cycle outputs default low; only the state entering
            // COMMIT/JUMP raises them for the following cycle.
            excepttype_q <= '0;
            inst_addr_q  <= '0;
            flush_q      <= 1'b0;
            new_pc_q     <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (arb_take) begin
                        code_q <= arb_code;
                        addr_q <= inst_addr_i;
                        hold_q <= 1'b1;
                        if (stall_i) begin
                            state_q <= ST_WAIT;
                        end else begin
                            state_q      <= ST_COMMIT;
                            excepttype_q <= arb_code;
                            inst_addr_q  <= inst_addr_i;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!stall_i) begin
                        state_q      <= ST_COMMIT;
                        excepttype_q <= code_q;
                        inst_addr_q  <= addr_q;
                    end
                end
                ST_COMMIT: begin
                    state_q  <= ST_JUMP;
                    flush_q  <= 1'b1;
                    new_pc_q <= jump_target_d;
                end
                ST_JUMP: begin
                    state_q <= ST_IDLE;
                    hold_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    hold_q  <= 1'b0;
                end
            endcase
        end
    end

    assign excepttype_o = excepttype_q;
    assign inst_addr_o  = inst_addr_q;
    assign hold_o       = hold_q;
    assign flush_o      = flush_q;
    assign new_pc_o     = new_pc_q;

endmodule

// File: tb/tb_trap_ctrl.sv
module tb_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        exc_valid_i;
    logic [31:0] exc_code_i;
    logic [31:0] inst_addr_i;
    logic        ext_int_i;
    logic        timer_int_i;
    logic [31:0] mstatus_i;
    logic [31:0] mie_i;
    logic [31:0] mtvec_i;
    logic [31:0] mepc_i;
    logic        stall_i;
    logic [31:0] excepttype_o;
    logic [31:0] inst_addr_o;
    logic        hold_o;
    logic        flush_o;
    logic [31:0] new_pc_o;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    trap_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .exc_valid_i  (exc_valid_i),
        .exc_code_i   (exc_code_i),
        .inst_addr_i  (inst_addr_i),
        .ext_int_i    (ext_int_i),
        .timer_int_i  (timer_int_i),
        .mstatus_i    (mstatus_i),
        .mie_i        (mie_i),
        .mtvec_i      (mtvec_i),
        .mepc_i       (mepc_i),
        .stall_i      (stall_i),
        .excepttype_o (excepttype_o),
        .inst_addr_o  (inst_addr_o),
        .hold_o       (hold_o),
        .flush_o      (flush_o),
        .new_pc_o     (new_pc_o)
    );

    // Reference: which trap (if any) an idle controller takes, as {take, code}.
    function automatic logic [32:0] ref_pick(input logic ev, input logic [31:0] code,
                                             input logic ext, input logic tim,
                                             input logic [31:0] ms, input logic [31:0] ie);
        if (ev && (code == 32'hB || code == 32'h2 || code == 32'hA)) return {1'b1, code};
        if (ext && ms[3] && ie[11]) return {1'b1, 32'h8000000B};
        if (tim && ms[3] && ie[7])  return {1'b1, 32'h80000007};
        return {1'b0, 32'h0};
    endfunction

    function automatic logic [31:0] ref_target(input logic [31:0] code,
                                               input logic [31:0] tvec, input logic [31:0] epc);
        return (code == 32'hA) ? epc : (tvec & 32'hFFFF_FFFC);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        exc_valid_i = 1'b0;
        exc_code_i  = '0;
        inst_addr_i = '0;
        ext_int_i   = 1'b0;
        timer_int_i = 1'b0;
        stall_i     = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        exc_valid_i = 1'b1; exc_code_i = 32'hB; inst_addr_i = 32'h1234;
        ext_int_i = 1'b1; timer_int_i = 1'b1;
        mstatus_i = 32'h8; mie_i = 32'hFFFF_FFFF; mtvec_i = 32'h80; mepc_i = 32'h0;
        stall_i = 1'b0;
        tick();
        tick();
        tests_run++;
        if ({hold_o, flush_o, excepttype_o, inst_addr_o, new_pc_o} !== 98'd0) begin
            tests_failed++;
            $display("FAIL reset_state: hold=%b flush=%b exc=%h addr=%h pc=%h, required all 0",
                     hold_o, flush_o, excepttype_o, inst_addr_o, new_pc_o);
        end
        clear_inputs();
        rst = 1'b0;
        tick();
        tests_run++;
        if ({hold_o, flush_o, excepttype_o} !== 34'd0) begin
            tests_failed++;
            $display("FAIL post_reset_idle: hold=%b flush=%b exc=%h, required 0", hold_o, flush_o, excepttype_o);
        end
    endtask

    task automatic test_ecall();
        clear_inputs();
        mstatus_i = 32'h0; mie_i = 32'h0; mtvec_i = 32'h80; mepc_i = 32'h0;
        exc_valid_i = 1'b1; exc_code_i = 32'hB; inst_addr_i = 32'h100;
        tick();
        exc_valid_i = 1'b0;
        tests_run++;
        if ({excepttype_o, inst_addr_o, hold_o, flush_o} !== {32'hB, 32'h100, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL ecall_commit: exc=%h addr=%h hold=%b flush=%b, required 0000000b 00000100 1 0",
                     excepttype_o, inst_addr_o, hold_o, flush_o);
        end
        tick();
        tests_run++;
        if ({flush_o, new_pc_o, excepttype_o} !== {1'b1, 32'h80, 32'h0}) begin
            tests_failed++;
            $display("FAIL ecall_jump: flush=%b pc=%h exc=%h, required 1 00000080 0", flush_o, new_pc_o, excepttype_o);
        end
        tick();
        tests_run++;
        if ({hold_o, flush_o, new_pc_o} !== 34'd0) begin
            tests_failed++;
            $display("FAIL ecall_idle: hold=%b flush=%b pc=%h, required 0", hold_o, flush_o, new_pc_o);
        end
    endtask

    task automatic test_mret();
        clear_inputs();
        mtvec_i = 32'h80; mepc_i = 32'h204;
        exc_valid_i = 1'b1; exc_code_i = 32'hA; inst_addr_i = 32'h300;
        tick();
        exc_valid_i = 1'b0;
        tests_run++;
        if (excepttype_o !== 32'hA) begin
            tests_failed++;
            $display("FAIL mret_commit: exc=%h, required 0000000a", excepttype_o);
        end
        tick();
        tests_run++;
        if ({flush_o, new_pc_o} !== {1'b1, 32'h204}) begin
            tests_failed++;
            $display("FAIL mret_jump: flush=%b pc=%h, required 1 00000204", flush_o, new_pc_o);
        end
        tick();
    endtask

    task automatic test_stall();
        clear_inputs();
        mstatus_i = 32'h8; mie_i = 32'h800; mtvec_i = 32'h443;
        ext_int_i = 1'b1; stall_i = 1'b1; inst_addr_i = 32'h55;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i == 2) stall_i = 1'b0;
            tests_run++;
            if ({hold_o, excepttype_o, flush_o} !== {1'b1, 32'h0, 1'b0}) begin
                tests_failed++;
                $display("FAIL stall_wait[%0d]: hold=%b exc=%h flush=%b, required 1 0 0", i, hold_o, excepttype_o, flush_o);
            end
        end
        tick();
        ext_int_i = 1'b0;
        tests_run++;
        if ({excepttype_o, inst_addr_o} !== {32'h8000000B, 32'h55}) begin
            tests_failed++;
            $display("FAIL stall_commit: exc=%h addr=%h, required 8000000b 00000055", excepttype_o, inst_addr_o);
        end
        tick();
        tests_run++;
        if ({flush_o, new_pc_o} !== {1'b1, 32'h440}) begin
            tests_failed++;
            $display("FAIL stall_jump: flush=%b pc=%h, required 1 00000440", flush_o, new_pc_o);
        end
        tick();
    endtask

    task automatic test_priority();
        clear_inputs();
        mstatus_i = 32'h8; mie_i = 32'h80; mtvec_i = 32'h80;
        timer_int_i = 1'b1;
        exc_valid_i = 1'b1; exc_code_i = 32'hB; inst_addr_i = 32'h10;
        tick();
        exc_valid_i = 1'b0;
        tests_run++;
        if (excepttype_o !== 32'hB) begin
            tests_failed++;
            $display("FAIL prio_exc_first: exc=%h, required 0000000b", excepttype_o);
        end
        tick();
        tick();
        tests_run++;
        if ({hold_o, excepttype_o} !== 33'd0) begin
            tests_failed++;
            $display("FAIL prio_back_idle: hold=%b exc=%h, required 0 0", hold_o, excepttype_o);
        end
        tick();
        timer_int_i = 1'b0;
        tests_run++;
        if (excepttype_o !== 32'h80000007) begin
            tests_failed++;
            $display("FAIL prio_timer_later: exc=%h, required 80000007", excepttype_o);
        end
        tick();
        tick();
    endtask

    task automatic test_mask();
        clear_inputs();
        mstatus_i = 32'hFFFF_FFF7; mie_i = 32'hFFFF_FFFF;
        timer_int_i = 1'b1; ext_int_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            tests_run++;
            if ({hold_o, excepttype_o, flush_o} !== 34'd0) begin
                tests_failed++;
                $display("FAIL mask_no_trap[%0d]: hold=%b exc=%h flush=%b, required 0", i, hold_o, excepttype_o, flush_o);
            end
        end
        clear_inputs();
    endtask

    task automatic test_unlisted();
        clear_inputs();
        mstatus_i = 32'h0;
        exc_valid_i = 1'b1; exc_code_i = 32'h5;
        for (int i = 0; i < 2; i++) begin
            tick();
            tests_run++;
            if ({hold_o, excepttype_o, flush_o} !== 34'd0) begin
                tests_failed++;
                $display("FAIL unlisted_ignored[%0d]: hold=%b exc=%h flush=%b, required 0", i, hold_o, excepttype_o, flush_o);
            end
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        clear_inputs();
        mtvec_i = 32'h80;
        exc_valid_i = 1'b1; exc_code_i = 32'h2; inst_addr_i = 32'h700;
        tick();
        exc_valid_i = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests_run++;
        if ({hold_o, flush_o, excepttype_o, inst_addr_o, new_pc_o} !== 98'd0) begin
            tests_failed++;
            $display("FAIL reset_mid: hold=%b flush=%b exc=%h addr=%h pc=%h, required all 0",
                     hold_o, flush_o, excepttype_o, inst_addr_o, new_pc_o);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            tests_run++;
            if ({hold_o, flush_o, excepttype_o} !== 34'd0) begin
                tests_failed++;
                $display("FAIL reset_mid_after[%0d]: hold=%b flush=%b exc=%h, required 0", i, hold_o, flush_o, excepttype_o);
            end
        end
    endtask

    task automatic test_random(input int n);
        logic [32:0] pick;
        logic [31:0] exp_code, exp_addr;
        int k;
        for (int t = 0; t < n; t++) begin
            mstatus_i = $urandom; mie_i = $urandom; mtvec_i = $urandom; mepc_i = $urandom;
            exc_valid_i = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: exc_code_i = 32'hB;
                1: exc_code_i = 32'h2;
                2: exc_code_i = 32'hA;
                default: exc_code_i = $urandom;
            endcase
            ext_int_i = 1'($urandom_range(0, 1));
            timer_int_i = 1'($urandom_range(0, 1));
            inst_addr_i = $urandom;
            k = $urandom_range(0, 3);
            stall_i = (k > 0);
            pick = ref_pick(exc_valid_i, exc_code_i, ext_int_i, timer_int_i, mstatus_i, mie_i);
            exp_code = pick[31:0];
            exp_addr = inst_addr_i;
            tick();
            if (!pick[32]) begin
                tests_run++;
                if ({hold_o, excepttype_o, flush_o} !== 34'd0) begin
                    tests_failed++;
                    $display("FAIL rnd_no_take[%0d]: hold=%b exc=%h flush=%b, required 0", t, hold_o, excepttype_o, flush_o);
                end
                continue;
            end
            // While busy, throw unrelated events at the controller; all must be ignored.
            for (int w = 0; w < k; w++) begin
                exc_valid_i = 1'($urandom_range(0, 1));
                exc_code_i = 32'hB;
                ext_int_i = 1'($urandom_range(0, 1));
                timer_int_i = 1'($urandom_range(0, 1));
                inst_addr_i = $urandom;
                tests_run++;
                if ({hold_o, excepttype_o, flush_o} !== {1'b1, 32'h0, 1'b0}) begin
                    tests_failed++;
                    $display("FAIL rnd_wait[%0d.%0d]: hold=%b exc=%h flush=%b, required 1 0 0", t, w, hold_o, excepttype_o, flush_o);
                end
                stall_i = (w < k - 1);
                tick();
            end
            exc_valid_i = 1'($urandom_range(0, 1));
            ext_int_i = 1'($urandom_range(0, 1));
            tests_run++;
            if ({excepttype_o, inst_addr_o, hold_o, flush_o} !== {exp_code, exp_addr, 1'b1, 1'b0}) begin
                tests_failed++;
                $display("FAIL rnd_commit[%0d]: exc=%h addr=%h hold=%b flush=%b, required %h %h 1 0",
                         t, excepttype_o, inst_addr_o, hold_o, flush_o, exp_code, exp_addr);
            end
            tick();
            tests_run++;
            if ({flush_o, new_pc_o, excepttype_o, hold_o} !== {1'b1, ref_target(exp_code, mtvec_i, mepc_i), 32'h0, 1'b1}) begin
                tests_failed++;
                $display("FAIL rnd_jump[%0d]: flush=%b pc=%h exc=%h hold=%b, required 1 %h 0 1",
                         t, flush_o, new_pc_o, excepttype_o, hold_o, ref_target(exp_code, mtvec_i, mepc_i));
            end
            tick();
            tests_run++;
            if ({hold_o, flush_o, excepttype_o, new_pc_o} !== 66'd0) begin
                tests_failed++;
                $display("FAIL rnd_idle[%0d]: hold=%b flush=%b exc=%h pc=%h, required 0", t, hold_o, flush_o, excepttype_o, new_pc_o);
            end
            clear_inputs();
        end
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        mstatus_i = '0; mie_i = '0; mtvec_i = '0; mepc_i = '0;
        test_reset();
        test_ecall();
        test_mret();
        test_stall();
        test_priority();
        test_mask();
        test_unlisted();
        test_reset_mid();
        test_random(200);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
